cursor_datapath: RTL and testbench

Datapath stage directly downstream of the etch-a-sketch controller FSM. It holds the cursor position, steps it one pixel on each `pos_en` pulse according to the direction buttons, and on each `plot_en` pulse scans a square sprite at the cursor into the VGA adapter, one pixel per clock. It turns the controller's single-cycle enables into the multi-cycle pixel-write stream the frame buffer needs.

---
 rtl/etch_pkg.sv | 18 +
 rtl/sprite_scan_counter.sv | 26 ++
 rtl/cursor_datapath.sv | 133 +++++++++++++
 tb/tb_cursor_datapath.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/etch_pkg.sv
// Shared etch-a-sketch constants and the sprite draw FSM state type.
// Used by the controller FSM and the cursor datapath.
package etch_pkg;

  localparam int COORD_X_W     = 8;
  localparam int COORD_Y_W     = 7;
  localparam int SCREEN_X_MAX  = 159;
  localparam int SCREEN_Y_MAX  = 119;
  localparam int SPRITE_LOG2   = 2;
  localparam int CURSOR_X_INIT = 80;
  localparam int CURSOR_Y_INIT = 60;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } draw_state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster scan index for the sprite; last flags the final pixel.
// start has priority over en and always restarts the scan at zero.
module sprite_scan_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = &cnt;

endmodule

// File: rtl/cursor_datapath.sv
// Cursor position register with clamped stepping, plus the sprite
// draw FSM that streams one registered pixel write per clock.
module cursor_datapath
  import etch_pkg::*;
#(
  parameter int X_W    = COORD_X_W,
  parameter int Y_W    = COORD_Y_W,
  parameter int X_MAX  = SCREEN_X_MAX,
  parameter int Y_MAX  = SCREEN_Y_MAX,
  parameter int S_LOG2 = SPRITE_LOG2,
  parameter int X_INIT = CURSOR_X_INIT,
  parameter int Y_INIT = CURSOR_Y_INIT
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           pos_en,
  input  logic           plot_en,
  input  logic           dir_up,
  input  logic           dir_down,
  input  logic           dir_left,
  input  logic           dir_right,
  input  logic [2:0]     colour_in,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy
);

  localparam int N = 2 * S_LOG2;
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX - (1 << S_LOG2) + 1);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX - (1 << S_LOG2) + 1);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  draw_state_t    state;
  draw_state_t    state_nxt;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic [X_W-1:0] ox;
  logic [Y_W-1:0] oy;
  logic [N-1:0]   cnt;
  logic [N-1:0]   cnt_nxt;
  logic           last;
  logic           accept;
  logic           step;

  // Clamped step; opposite buttons cancel on their axis.
  always_comb begin
    x_nxt = cur_x;
    y_nxt = cur_y;
    if (dir_right && !dir_left && cur_x < X_LIM) begin
      x_nxt = cur_x + X_ONE;
    end else if (dir_left && !dir_right && cur_x != '0) begin
      x_nxt = cur_x - X_ONE;
    end
    if (dir_down && !dir_up && cur_y < Y_LIM) begin
      y_nxt = cur_y + Y_ONE;
    end else if (dir_up && !dir_down && cur_y != '0) begin
      y_nxt = cur_y - Y_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_x <= X_W'(X_INIT);
      cur_y <= Y_W'(Y_INIT);
    end else if (pos_en) begin
      cur_x <= x_nxt;
      cur_y <= y_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (plot_en) state_nxt = S_DRAW;
      S_DRAW: if (last && !plot_en) state_nxt = S_IDLE;
    endcase
  end

  // A new draw is taken in IDLE or on the final pixel cycle.
  always_comb begin
    accept = plot_en && (state == S_IDLE || last);
    step   = (state == S_DRAW) && !last;
  end

  sprite_scan_counter #(
    .W(N)
  ) u_scan (
    .clk   (clk),
    .resetn(resetn),
    .start (accept),
    .en    (step),
    .cnt   (cnt),
    .last  (last)
  );

  assign cnt_nxt = cnt + N'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ox         <= '0;
      oy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else if (accept) begin
      ox         <= cur_x;
      oy         <= cur_y;
      vga_x      <= cur_x;
      vga_y      <= cur_y;
      vga_colour <= colour_in;
    end else if (step) begin
      vga_x <= ox + {{(X_W-S_LOG2){1'b0}}, cnt_nxt[S_LOG2-1:0]};
      vga_y <= oy + {{(Y_W-S_LOG2){1'b0}}, cnt_nxt[N-1:S_LOG2]};
    end
  end

  assign busy     = (state == S_DRAW);
  assign vga_plot = (state == S_DRAW);

endmodule

// File: tb/tb_cursor_datapath.sv
// Scoreboard bench for cursor_datapath: expected pixel writes are
// queued by stimulus and popped by a monitor on every vga_plot cycle.
module tb_cursor_datapath;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pos_en;
  logic       plot_en;
  logic       dir_up;
  logic       dir_down;
  logic       dir_left;
  logic       dir_right;
  logic [2:0] colour_in;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int mx;
  int my;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t sb[$];

  cursor_datapath dut (
    .clk       (clk),
    .resetn    (resetn),
    .pos_en    (pos_en),
    .plot_en   (plot_en),
    .dir_up    (dir_up),
    .dir_down  (dir_down),
    .dir_left  (dir_left),
    .dir_right (dir_right),
    .colour_in (colour_in),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest queued pixel.
  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got (%0d,%0d,%0d) expected none",
                 vga_x, vga_y, vga_colour);
      end else begin
        pix_t e;
        e = sb.pop_front();
        if (vga_x != e.x || vga_y != e.y || vga_colour != e.c) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic push_sprite(input int x, input int y, input int c,
                             input int n);
    for (int i = 0; i < n; i++) begin
      pix_t p;
      p.x = x + (i % 4);
      p.y = y + (i / 4);
      p.c = c;
      sb.push_back(p);
    end
  endtask

  task automatic model_step(input bit r, input bit l, input bit d,
                            input bit u);
    if (r && !l && mx < 156) mx++;
    else if (l && !r && mx > 0) mx--;
    if (d && !u && my < 116) my++;
    else if (u && !d && my > 0) my--;
  endtask

  task automatic step(input bit r, input bit l, input bit d, input bit u);
    pos_en = 1'b1;
    dir_right = r;
    dir_left = l;
    dir_down = d;
    dir_up = u;
    @(posedge clk);
    #1;
    pos_en = 1'b0;
    {dir_right, dir_left, dir_down, dir_up} = 4'b0;
    model_step(r, l, d, u);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mx = 80;
    my = 60;
  endtask

  task automatic pulse_plot(input logic [2:0] c);
    plot_en = 1'b1;
    colour_in = c;
    @(posedge clk);
    #1;
    plot_en = 1'b0;
  endtask

  // Count busy cycles until the draw ends; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  int n;

  initial begin
    resetn = 1'b0;
    {pos_en, plot_en, dir_up, dir_down, dir_left, dir_right} = '0;
    colour_in = '0;
    do_reset();
    @(negedge clk);
    chk("rst_cur_x", cur_x, 80);
    chk("rst_cur_y", cur_y, 60);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);

    // Basic draw at the reset position.
    @(posedge clk);
    #1;
    push_sprite(80, 60, 3'b100, 16);
    pulse_plot(3'b100);
    wait_idle(n);
    chk("draw1_busy_cycles", n, 16);
    chk("draw1_drained", sb.size(), 0);
    chk("draw1_plot_low", vga_plot, 0);
    chk("draw1_hold_x", vga_x, 83);
    chk("draw1_hold_y", vga_y, 63);

    // Diagonal steps, then a cancelled x axis.
    repeat (5) step(1, 0, 1, 0);
    @(negedge clk);
    chk("diag_x", cur_x, 85);
    chk("diag_y", cur_y, 65);
    step(1, 1, 0, 1);
    @(negedge clk);
    chk("cancel_x", cur_x, 85);
    chk("cancel_y", cur_y, 64);

    // Clamp at all four limits.
    repeat (90) step(0, 1, 0, 0);
    @(negedge clk);
    chk("clamp_x0", cur_x, 0);
    repeat (170) step(1, 0, 0, 0);
    @(negedge clk);
    chk("clamp_x156", cur_x, 156);
    repeat (70) step(0, 0, 0, 1);
    @(negedge clk);
    chk("clamp_y0", cur_y, 0);
    repeat (125) step(0, 0, 1, 0);
    @(negedge clk);
    chk("clamp_y116", cur_y, 116);
    chk("clamp_model_x", cur_x, mx);
    chk("clamp_model_y", cur_y, my);

    // Draw at the corner; a mid-draw plot_en is dropped.
    @(posedge clk);
    #1;
    push_sprite(mx, my, 3'b011, 16);
    pulse_plot(3'b011);
    repeat (4) @(posedge clk);
    #1;
    pulse_plot(3'b111);
    wait_idle(n);
    chk("ignore_busy_cycles", n, 11);
    repeat (3) @(negedge clk);
    chk("ignore_drained", sb.size(), 0);

    // Back-to-back draws with no gap.
    @(posedge clk);
    #1;
    push_sprite(mx, my, 3'b001, 16);
    push_sprite(mx, my, 3'b010, 16);
    pulse_plot(3'b001);
    repeat (15) @(posedge clk);
    #1;
    pulse_plot(3'b010);
    wait_idle(n);
    chk("b2b_busy_cycles", n, 16);
    chk("b2b_drained", sb.size(), 0);

    // Draw and step in the same cycle from (80,60).
    do_reset();
    push_sprite(80, 60, 3'b110, 16);
    pos_en = 1'b1;
    dir_right = 1'b1;
    pulse_plot(3'b110);
    pos_en = 1'b0;
    dir_right = 1'b0;
    wait_idle(n);
    chk("same_busy_cycles", n, 16);
    chk("same_cur_x", cur_x, 81);
    chk("same_drained", sb.size(), 0);

    // Reset aborts a draw after pixels 0..6.
    @(posedge clk);
    #1;
    push_sprite(81, 60, 3'b101, 7);
    pulse_plot(3'b101);
    repeat (6) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_plot", vga_plot, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cur_x", cur_x, 80);
    chk("abort_cur_y", cur_y, 60);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
